conv_bram_sr_fast_ctrl: RTL

- Sequencing controller for the row-banked BRAM shift-register convolution datapath.
- Image channel rows are stored across FILTER_L BRAM banks: row h lives in bank h%FILTER_L at address (h/FILTER_L)*IMG_W + w.
- Per output row, the block sweeps image columns and drives per-bank read addresses, column shift enables, rotation offset, result-emit strobe and result write address into the datapath.
- A start/busy/done handshake frames one full convolution pass; done is taken from the datapath's last_val.

---
 rtl/conv_bram_sr_fast_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/conv_bram_sr_fast_ctrl.sv
// Sequencing controller for the row-banked BRAM shift-register convolution datapath.
// Sweeps image columns per output row, generates per-bank read addresses and a
// RAM_LAT-deep delay line of datapath controls aligned with BRAM read data.
module conv_bram_sr_fast_ctrl #(
   parameter int unsigned IMG_W    = 16,
   parameter int unsigned IMG_H    = 16,
   parameter int unsigned FILTER_L = 3,
   parameter int unsigned STRIDE_W = 1,
   parameter int unsigned STRIDE_H = 1,
   parameter int unsigned RAM_LAT  = 1,
   localparam int unsigned RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1,
   localparam int unsigned RESULT_H = (IMG_H - FILTER_L) / STRIDE_H + 1,
   localparam int unsigned BANK_ADDR_WIDTH =
      $clog2(IMG_W * ((IMG_H + FILTER_L - 1) / FILTER_L)),
   localparam int unsigned FILTER_L_ADDR_WIDTH = (FILTER_L > 1) ? $clog2(FILTER_L) : 1,
   localparam int unsigned RESULT_RAM_ADDR_WIDTH =
      (RESULT_W * RESULT_H > 1) ? $clog2(RESULT_W * RESULT_H) : 1
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      start,
   output logic                                      busy,
   output logic                                      done,
   output logic [FILTER_L*BANK_ADDR_WIDTH-1:0]       img_rdaddr,
   output logic                                      img_rden,
   output logic                                      dpath_wren,
   output logic                                      dpath_sum_en,
   output logic [FILTER_L_ADDR_WIDTH-1:0]            dpath_rotation_offset,
   output logic [RESULT_RAM_ADDR_WIDTH-1:0]          dpath_result_wraddr,
   input  logic                                      last_val
);

   localparam int unsigned BAW = BANK_ADDR_WIDTH;
   localparam int unsigned FLW = FILTER_L_ADDR_WIDTH;
   localparam int unsigned RAW = RESULT_RAM_ADDR_WIDTH;
   localparam int unsigned WW  = $clog2(IMG_W + 1);
   localparam int unsigned RCW = $clog2(RESULT_H + 1);
   localparam int unsigned PW  = $clog2(STRIDE_W + 1);

   // Vertical stride split into whole row-groups and a residual bank rotation.
   localparam int unsigned HStepQ = STRIDE_H / FILTER_L;
   localparam int unsigned HStepM = STRIDE_H % FILTER_L;
   localparam logic [BAW-1:0] IncLo = BAW'(HStepQ * IMG_W);
   localparam logic [BAW-1:0] IncHi = BAW'((HStepQ + 1) * IMG_W);

   localparam logic [WW-1:0]  WLast  = WW'(IMG_W - 1);
   localparam logic [WW-1:0]  WFirst = WW'(FILTER_L - 1);
   localparam logic [RCW-1:0] RLast  = RCW'(RESULT_H - 1);
   localparam logic [PW-1:0]  PLast  = PW'(STRIDE_W - 1);

   typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

   state_e           state_q;
   logic [WW-1:0]    w_q;
   logic [RCW-1:0]   r_q;
   logic [FLW-1:0]   rot_q, rot_nxt;
   logic [PW-1:0]    ph_q;
   logic [RAW-1:0]   wraddr_q;
   logic             last_seen_q;
   // Address of column 0 of the image row currently mapped to each bank.
   logic [BAW-1:0]   rowaddr_q   [FILTER_L];
   logic [BAW-1:0]   rowaddr_nxt [FILTER_L];

   logic [RAM_LAT-1:0] pipe_rden_q, pipe_sum_q;
   logic [FLW-1:0]     pipe_rot_q [RAM_LAT];
   logic [RAW-1:0]     pipe_wa_q  [RAM_LAT];

   logic feed, sum_raw, pipe_empty;
   logic [FLW-1:0] rot_raw;

   assign feed       = (state_q == StFeed);
   // ph_q tracks the horizontal stride phase once the window is full.
   assign sum_raw    = feed && (w_q >= WFirst) && (ph_q == '0);
   assign rot_raw    = feed ? rot_q : '0;
   assign pipe_empty = ~|pipe_rden_q;

   // Next-row rotation and per-bank row base, stepped without a divider.
   always_comb begin
      int unsigned t;
      int unsigned d;
      t = 32'(rot_q) + HStepM;
      if (t >= FILTER_L) t = t - FILTER_L;
      rot_nxt = FLW'(t);
      for (int unsigned b = 0; b < FILTER_L; b++) begin
         d = (b >= 32'(rot_q)) ? (b - 32'(rot_q)) : (b + FILTER_L - 32'(rot_q));
         rowaddr_nxt[b] = rowaddr_q[b] + ((d >= HStepM) ? IncLo : IncHi);
      end
   end

   // Per-bank read address for the current column.
   always_comb begin
      img_rdaddr = '0;
      for (int unsigned b = 0; b < FILTER_L; b++) begin
         if (feed) img_rdaddr[b*BAW +: BAW] = rowaddr_q[b] + BAW'(w_q);
      end
   end

   // Control FSM with column/row/result counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         w_q         <= '0;
         r_q         <= '0;
         rot_q       <= '0;
         ph_q        <= '0;
         wraddr_q    <= '0;
         last_seen_q <= 1'b0;
         for (int unsigned b = 0; b < FILTER_L; b++) rowaddr_q[b] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q     <= StFeed;
                  w_q         <= '0;
                  r_q         <= '0;
                  rot_q       <= '0;
                  ph_q        <= '0;
                  wraddr_q    <= '0;
                  last_seen_q <= 1'b0;
                  for (int unsigned b = 0; b < FILTER_L; b++) rowaddr_q[b] <= '0;
               end
            end
            StFeed: begin
               if (last_val) last_seen_q <= 1'b1;
               if (sum_raw) wraddr_q <= wraddr_q + RAW'(1);
               if (w_q == WLast) begin
                  w_q  <= '0;
                  ph_q <= '0;
                  if (r_q == RLast) begin
                     state_q <= StDrain;
                  end else begin
                     r_q       <= r_q + RCW'(1);
                     rot_q     <= rot_nxt;
                     rowaddr_q <= rowaddr_nxt;
                  end
               end else begin
                  w_q <= w_q + WW'(1);
                  if (w_q >= WFirst) ph_q <= (ph_q == PLast) ? '0 : ph_q + PW'(1);
               end
            end
            StDrain: begin
               if (last_val) last_seen_q <= 1'b1;
               if (pipe_empty && (last_seen_q || last_val)) state_q <= StDone;
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Delay line aligning datapath controls with BRAM read data; wraddr holds between emits.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pipe_rden_q <= '0;
         pipe_sum_q  <= '0;
         for (int unsigned k = 0; k < RAM_LAT; k++) begin
            pipe_rot_q[k] <= '0;
            pipe_wa_q[k]  <= '0;
         end
      end else begin
         pipe_rden_q[0] <= feed;
         pipe_sum_q[0]  <= sum_raw;
         pipe_rot_q[0]  <= rot_raw;
         if (sum_raw) pipe_wa_q[0] <= wraddr_q;
         for (int unsigned k = 1; k < RAM_LAT; k++) begin
            pipe_rden_q[k] <= pipe_rden_q[k-1];
            pipe_sum_q[k]  <= pipe_sum_q[k-1];
            pipe_rot_q[k]  <= pipe_rot_q[k-1];
            if (pipe_sum_q[k-1]) pipe_wa_q[k] <= pipe_wa_q[k-1];
         end
      end
   end

   assign busy                  = (state_q == StFeed) || (state_q == StDrain);
   assign done                  = (state_q == StDone);
   assign img_rden              = feed;
   assign dpath_wren            = pipe_rden_q[RAM_LAT-1];
   assign dpath_sum_en          = pipe_sum_q[RAM_LAT-1];
   assign dpath_rotation_offset = pipe_rot_q[RAM_LAT-1];
   assign dpath_result_wraddr   = pipe_wa_q[RAM_LAT-1];

endmodule
